// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared types and constants for the MIPS execute-stage multiply/divide unit.
//   muldiv_op_t    : 3-bit operation code driven by the control unit
//   muldiv_state_t : sequencer states of mips_cpu_muldiv
//   MULDIV_WIDTH   : default datapath width (operands, HI, LO)
//   MULDIV_ITER    : default iteration count (one bit per cycle)
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_ITER  = MULDIV_WIDTH;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// ---------------------------------------------------------------------------
// mips_cpu_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem_in       : partial remainder, always < divisor on entry
//   dividend_bit : next dividend bit shifted in at the bottom
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
// ---------------------------------------------------------------------------
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;

  // Trial subtraction; the difference is < divisor when taken, so WIDTH bits suffice.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = shifted_s[WIDTH-1:0] - divisor;
    if (shifted_s >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = diff_s;
    end else begin
      q_bit   = 1'b0;
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// mips_cpu_muldiv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (iterative, WIDTH+1 busy cycles) and
// MTHI/MTLO (single-edge write, never busy).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start, op    : request and muldiv_op_t opcode, sampled only in IDLE
//   op_a, op_b   : rs / rt operands, captured at acceptance
//   busy         : high while a mult/div is in flight
//   done         : one-cycle pulse when a mult/div updates HI/LO
//   hi, lo       : HI and LO registers
// Build option: MULDIV_FAST_MULT_EN - MULT/MULTU use one combinational
// multiplier and skip CALC (busy for a single cycle). DIV/DIVU unchanged.
// ---------------------------------------------------------------------------
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITER
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0] opnd_q, opnd_d;   // mult: multiplicand; div: divisor (magnitudes)
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;     // product / quotient must be negated
  logic             sa_q, sa_d;       // signed dividend was negative
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  muldiv_op_t       op_e;
  logic             is_signed_s, a_sign_s, b_sign_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_s;
  logic [WIDTH-1:0] rem_next_s, rem_s, quot_s;
  logic             q_bit_s;

  assign op_e = muldiv_op_t'(op);

  // Operand magnitudes for signed ops; unsigned ops pass raw values through.
  always_comb begin
    is_signed_s = (op_e == OP_MULT) || (op_e == OP_DIV);
    a_sign_s    = is_signed_s & op_a[WIDTH-1];
    b_sign_s    = is_signed_s & op_b[WIDTH-1];
    a_mag_s     = a_sign_s ? (-op_a) : op_a;
    b_mag_s     = b_sign_s ? (-op_b) : op_b;
  end

  // Radix-2 shift-add: add multiplicand when the current multiplier bit is set, then shift right.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
  end

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc_q[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc_q[WIDTH-1]),
    .divisor      (opnd_q),
    .rem_out      (rem_next_s),
    .q_bit        (q_bit_s)
  );

  // Remainder takes the next dividend bit; quotient bit enters at the bottom.
  always_comb begin
    div_next_s = {rem_next_s, acc_q[WIDTH-2:0], q_bit_s};
    rem_s      = acc_q[2*WIDTH-1:WIDTH];
    quot_s     = acc_q[WIDTH-1:0];
  end

  // Unsigned product magnitude presented to the FIX state.
  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod_s = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
    prod_s = acc_q;
`endif
  end

  // Sequencer next-state and HI/LO update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
              opnd_d   = a_mag_s;
              acc_d    = {{WIDTH{1'b0}}, b_mag_s};
              is_div_d = 1'b0;
              neg_d    = a_sign_s ^ b_sign_s;
              sa_d     = a_sign_s;
              div0_d   = 1'b0;
              cnt_d    = '0;
`ifdef MULDIV_FAST_MULT_EN
              state_d  = ST_FIX;
`else
              state_d  = ST_CALC;
`endif
            end
            OP_DIV, OP_DIVU: begin
              opnd_d   = b_mag_s;
              acc_d    = {{WIDTH{1'b0}}, a_mag_s};
              is_div_d = 1'b1;
              neg_d    = a_sign_s ^ b_sign_s;
              sa_d     = a_sign_s;
              div0_d   = (op_b == {WIDTH{1'b0}});
              cnt_d    = '0;
              state_d  = ST_CALC;
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = is_div_q ? div_next_s : mul_next_s;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          // With a zero divisor the dividend shifts straight into the remainder,
          // so restoring its sign recovers the original op_a for HI.
          hi_d = sa_q ? (-rem_s) : rem_s;
          if (div0_q) begin
            lo_d = {WIDTH{1'b1}};
          end else begin
            lo_d = neg_q ? (-quot_s) : quot_s;
          end
        end else begin
          {hi_d, lo_d} = neg_q ? (-prod_s) : prod_s;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_muldiv
// Directed self-checking bench for mips_cpu_muldiv (WIDTH=32). Inputs change
// on the falling edge; outputs are sampled on the falling edge. Expected
// latencies follow MULDIV_FAST_MULT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mips_cpu_muldiv;

  localparam int DIV_LAT = 33;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request for one edge, then scramble the operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0; op_a = $urandom; op_b = $urandom;
  endtask

  // Count falling edges with busy high (bounded), note early done pulses.
  task automatic wait_idle(output int cyc, output int early, output logic dend);
    cyc = 0; early = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (done === 1'b1) early++;
      cyc++;
      @(negedge clk);
    end
    dend = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; op = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {busy, done}); else passed++;
    total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    total++; if ({busy, done, hi, lo} !== 66'h0) $display("FAIL reset_release: got %h want 0", {busy, done, hi, lo}); else passed++;
  endtask

  task automatic test_mult();
    logic [2:0]  ops [6] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd2};
    logic [31:0] as  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000, 32'h00000007, 32'h00010000};
    logic [31:0] bs  [6] = '{32'h00000003, 32'h00000003, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFB, 32'h00010000};
    logic [63:0] ex  [6] = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA, 64'hFFFFFFFE_00000001,
                             64'h40000000_00000000, 64'hFFFFFFFF_FFFFFFDD, 64'h00000001_00000000};
    int cyc, early; logic dend;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_idle(cyc, early, dend);
      total++; if (cyc != MUL_LAT) $display("FAIL mult_busy[%0d]: got %0d cycles want %0d", i, cyc, MUL_LAT); else passed++;
      total++; if (dend !== 1'b1 || early != 0) $display("FAIL mult_done[%0d]: got end=%b early=%0d want 1/0", i, dend, early); else passed++;
      total++; if ({hi, lo} !== ex[i]) $display("FAIL mult_result[%0d]: got %h want %h", i, {hi, lo}, ex[i]); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL mult_pulse[%0d]: got %b want 0", i, done); else passed++;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [6] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd3};
    logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'd100, 32'd7, 32'h12345678, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] bs  [6] = '{32'd2, 32'd7, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [31:0] eh  [6] = '{32'hFFFFFFFF, 32'd2, 32'd1, 32'h12345678, 32'h0, 32'hFFFFFFF9};
    logic [31:0] el  [6] = '{32'hFFFFFFFD, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    int cyc, early; logic dend;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_idle(cyc, early, dend);
      total++; if (cyc != DIV_LAT) $display("FAIL div_busy[%0d]: got %0d cycles want %0d", i, cyc, DIV_LAT); else passed++;
      total++; if (dend !== 1'b1 || early != 0) $display("FAIL div_done[%0d]: got end=%b early=%0d want 1/0", i, dend, early); else passed++;
      total++; if (hi !== eh[i]) $display("FAIL div_hi[%0d]: got %h want %h", i, hi, eh[i]); else passed++;
      total++; if (lo !== el[i]) $display("FAIL div_lo[%0d]: got %h want %h", i, lo, el[i]); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL div_pulse[%0d]: got %b want 0", i, done); else passed++;
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    lo_before = lo;
    start = 1'b1; op = 3'd5; op_a = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (hi !== 32'hDEADBEEF || lo !== lo_before) $display("FAIL mthi: got hi=%h lo=%h want DEADBEEF/%h", hi, lo, lo_before); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL mthi_flags: got %b want 00", {busy, done}); else passed++;
    op = 3'd6; op_a = 32'h0BADF00D;
    @(negedge clk);
    total++; if (lo !== 32'h0BADF00D || hi !== 32'hDEADBEEF) $display("FAIL mtlo: got hi=%h lo=%h want DEADBEEF/0BADF00D", hi, lo); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL mtlo_flags: got %b want 00", {busy, done}); else passed++;
    op = 3'd7; op_a = 32'h55555555;
    @(negedge clk);
    op = 3'd0; op_a = 32'h66666666;
    @(negedge clk);
    start = 1'b0;
    total++; if ({busy, done, hi, lo} !== {2'b00, 32'hDEADBEEF, 32'h0BADF00D}) $display("FAIL noop_ops: got %h want 0DEADBEEF0BADF00D", {busy, done, hi, lo}); else passed++;
  endtask

  task automatic test_ignore_start();
    int cyc, early; logic dend;
    start = 1'b1; op = 3'd2; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", busy); else passed++;
    total++; if ({hi, lo} !== {32'hDEADBEEF, 32'h0BADF00D}) $display("FAIL ign_hold: got %h want DEADBEEF0BADF00D", {hi, lo}); else passed++;
    op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(cyc, early, dend);
    total++; if (cyc + 1 != MUL_LAT) $display("FAIL ign_latency: got %0d cycles want %0d", cyc + 1, MUL_LAT); else passed++;
    total++; if (dend !== 1'b1 || early != 0) $display("FAIL ign_done: got end=%b early=%0d want 1/0", dend, early); else passed++;
    total++; if ({hi, lo} !== 64'd15) $display("FAIL ign_result: got %h want 15", {hi, lo}); else passed++;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("FAIL ign_second: got %b want 00", {busy, done}); else passed++;
  endtask

  task automatic test_reset_mid_div();
    int seen_done = 0;
    issue(3'd5, 32'h11111111, 32'h0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1 || hi !== 32'h11111111) $display("FAIL rst_mid_pre: got busy=%b hi=%h want 1/11111111", busy, hi); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL rst_mid_flags: got %b want 00", {busy, done}); else passed++;
    total++; if ({hi, lo} !== 64'h0) $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++; if (seen_done != 0) $display("FAIL rst_mid_after: got %0d active cycles want 0", seen_done); else passed++;
    total++; if ({hi, lo} !== 64'h0) $display("FAIL rst_mid_final: got %h want 0", {hi, lo}); else passed++;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'd0; op_a = '0; op_b = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_ignore_start();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
